// File: rtl/clk_switch_ctrl_if.sv
// Select/gate bundle between a clock-switch requester and the clk_switch_ctrl
// supervisor. The requester (master) issues select requests and returns the
// per-source gate acknowledgements; the supervisor (slave) drives the gates
// and reports status.
interface clk_switch_ctrl_if #(
   parameter int N_CLK = 4
);
   localparam int SEL_W = $clog2(N_CLK);

   logic [SEL_W-1:0] sel_req;
   logic             sel_valid;
   logic             sel_ready;
   logic [N_CLK-1:0] gate_en;
   logic [N_CLK-1:0] gate_ack;
   logic [SEL_W-1:0] cur_sel;
   logic             busy;
   logic             switch_done;
   logic             err;

   modport master (
      output sel_req, sel_valid, gate_ack,
      input  sel_ready, gate_en, cur_sel, busy, switch_done, err
   );

   modport slave (
      input  sel_req, sel_valid, gate_ack,
      output sel_ready, gate_en, cur_sel, busy, switch_done, err
   );
endinterface

// File: rtl/clk_switch_ctrl.sv
// Control-domain sequencer for an N-input glitch-free clock switch.
// A select request runs a break-before-make sequence: drop the active gate,
// wait for its (synchronised) ack to fall, raise the new gate, wait for its
// ack to rise. Gate enables are registered and never have two bits set.
// Optional feature: define CLK_SWITCH_TIMEOUT_EN to bound each ack wait to
// TIMEOUT cycles; on expiry err is set, all gates stay off, and the block
// returns to IDLE with cur_sel unchanged.
module clk_switch_ctrl #(
   parameter int N_CLK       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int RESET_SEL   = 0,
   parameter int TIMEOUT     = 255
) (
   input  logic              clk,
   input  logic              rst,
   clk_switch_ctrl_if.slave  bus
);
   localparam int               SEL_W    = $clog2(N_CLK);
   localparam logic [SEL_W:0]   N_LIM    = (SEL_W+1)'(N_CLK);
   localparam logic [N_CLK-1:0] ONE_HOT0 = N_CLK'(1);
   localparam logic [N_CLK-1:0] GATE_RST = ONE_HOT0 << RESET_SEL;
   localparam logic [SEL_W-1:0] SEL_RST  = SEL_W'(RESET_SEL);

   // Reject parameter sets the sequencer cannot support.
   if (N_CLK < 2 || N_CLK > 16 || SYNC_STAGES < 2 || RESET_SEL >= N_CLK || TIMEOUT < 1) begin : g_param_check
      $error("clk_switch_ctrl: illegal parameter combination");
   end

   typedef enum logic [2:0] {IDLE, DROP, WAIT_OFF, RAISE, WAIT_ON} state_t;

   state_t           state, state_nxt;
   logic [N_CLK-1:0] gate_en_r, gate_en_nxt;
   logic [SEL_W-1:0] cur_sel_r, cur_sel_nxt;
   logic [SEL_W-1:0] target, target_nxt;
   logic             busy_r, busy_nxt;
   logic             done_r, done_nxt;
   logic             err_r, err_nxt;

   logic [N_CLK-1:0] ack_sync [SYNC_STAGES];
   logic [N_CLK-1:0] ack_s;

`ifdef CLK_SWITCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
   assign cnt_inc = cnt + CNT_W'(1);
`endif

   // Bring the asynchronous gate acks into the clk domain.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) ack_sync[k] <= '0;
      end else begin
         ack_sync[0] <= bus.gate_ack;
         for (int k = 1; k < SYNC_STAGES; k++) ack_sync[k] <= ack_sync[k-1];
      end
   end

   assign ack_s = ack_sync[SYNC_STAGES-1];

   // State and registered outputs; reset re-enables the reset source from any state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         gate_en_r <= GATE_RST;
         cur_sel_r <= SEL_RST;
         target    <= SEL_RST;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
`ifdef CLK_SWITCH_TIMEOUT_EN
         cnt       <= '0;
`endif
      end else begin
         state     <= state_nxt;
         gate_en_r <= gate_en_nxt;
         cur_sel_r <= cur_sel_nxt;
         target    <= target_nxt;
         busy_r    <= busy_nxt;
         done_r    <= done_nxt;
         err_r     <= err_nxt;
`ifdef CLK_SWITCH_TIMEOUT_EN
         cnt       <= cnt_nxt;
`endif
      end
   end

   // Next-state logic for the break-before-make sequence.
   always_comb begin
      state_nxt   = state;
      gate_en_nxt = gate_en_r;
      cur_sel_nxt = cur_sel_r;
      target_nxt  = target;
      busy_nxt    = busy_r;
      done_nxt    = 1'b0;
      err_nxt     = err_r;
`ifdef CLK_SWITCH_TIMEOUT_EN
      cnt_nxt     = cnt;
`endif
      unique case (state)
         IDLE: begin
            if (bus.sel_valid) begin
               if ({1'b0, bus.sel_req} >= N_LIM) begin
                  err_nxt = 1'b1;
               end else if (bus.sel_req == cur_sel_r && gate_en_r != '0) begin
                  // Already on this source: acknowledge without touching the gates.
                  err_nxt  = 1'b0;
                  done_nxt = 1'b1;
               end else begin
                  // A stopped clock (gates all off after a timeout) also restarts here.
                  err_nxt    = 1'b0;
                  target_nxt = bus.sel_req;
                  busy_nxt   = 1'b1;
                  state_nxt  = DROP;
               end
            end
         end
         DROP: begin
            gate_en_nxt = '0;
            state_nxt   = WAIT_OFF;
`ifdef CLK_SWITCH_TIMEOUT_EN
            cnt_nxt     = '0;
`endif
         end
         WAIT_OFF: begin
            if (!ack_s[cur_sel_r]) begin
               state_nxt = RAISE;
`ifdef CLK_SWITCH_TIMEOUT_EN
            end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
               err_nxt     = 1'b1;
               gate_en_nxt = '0;
               busy_nxt    = 1'b0;
               state_nxt   = IDLE;
            end else begin
               cnt_nxt = cnt_inc;
`endif
            end
         end
         RAISE: begin
            gate_en_nxt = ONE_HOT0 << target;
            state_nxt   = WAIT_ON;
`ifdef CLK_SWITCH_TIMEOUT_EN
            cnt_nxt     = '0;
`endif
         end
         WAIT_ON: begin
            if (ack_s[target]) begin
               cur_sel_nxt = target;
               busy_nxt    = 1'b0;
               done_nxt    = 1'b1;
               state_nxt   = IDLE;
`ifdef CLK_SWITCH_TIMEOUT_EN
            end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
               err_nxt     = 1'b1;
               gate_en_nxt = '0;
               busy_nxt    = 1'b0;
               state_nxt   = IDLE;
            end else begin
               cnt_nxt = cnt_inc;
`endif
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.sel_ready   = (state == IDLE);
   assign bus.gate_en     = gate_en_r;
   assign bus.cur_sel     = cur_sel_r;
   assign bus.busy        = busy_r;
   assign bus.switch_done = done_r;
   assign bus.err         = err_r;
endmodule
